// File: rtl/mem_arbiter.sv
// Two-requester (instruction/data) arbiter onto a single memory port: round-robin
// grant, registered memory strobes, read timeout and a one-cycle GAP per transaction.
module mem_arbiter #(
    parameter int unsigned LINE_W  = 512,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd,
    input  logic [63:0]       i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_dv,
    output logic              i_err,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [63:0]       d_addr,
    input  logic [63:0]       d_wdata,
    input  logic [1:0]        d_len,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_dv,
    output logic              d_err,
    output logic [63:0]       mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [1:0]        mem_len,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_dv
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RD_I, RD_D, WR_D, GAP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_i_q, last_i_d;   // instruction side held the last grant
    logic [63:0]        mem_addr_q, mem_addr_d;
    logic [63:0]        mem_wdata_q, mem_wdata_d;
    logic [1:0]         mem_len_q, mem_len_d;
    logic               mem_rd_q, mem_rd_d;
    logic               mem_wr_q, mem_wr_d;
    logic               i_dv_q, i_dv_d;
    logic               d_dv_q, d_dv_d;
    logic               i_err_q, i_err_d;
    logic               d_err_q, d_err_d;
    logic [LINE_W-1:0]  i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0]  d_rdata_q, d_rdata_d;
    logic               grant_d, grant_i;

    always_comb begin
        grant_d = (d_rd || d_wr) && (!i_rd || last_i_q);
        grant_i = i_rd && !grant_d;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_i_d    = last_i_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_len_d   = mem_len_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        i_dv_d      = 1'b0;
        d_dv_d      = 1'b0;
        i_err_d     = 1'b0;
        d_err_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    last_i_d   = 1'b0;
                    mem_addr_d = d_addr;
                    cnt_d      = '0;
                    if (d_wr) begin
                        state_d     = WR_D;
                        mem_wr_d    = 1'b1;
                        mem_wdata_d = d_wdata;
                        mem_len_d   = d_len;
                    end else begin
                        state_d  = RD_D;
                        mem_rd_d = 1'b1;
                    end
                end else if (grant_i) begin
                    last_i_d   = 1'b1;
                    mem_addr_d = i_addr;
                    cnt_d      = '0;
                    state_d    = RD_I;
                    mem_rd_d   = 1'b1;
                end
            end
            RD_I, RD_D: begin
                // Response wins over a timeout landing in the same cycle.
                if (mem_dv) begin
                    if (state_q == RD_I) begin
                        i_rdata_d = mem_rdata;
                        i_dv_d    = 1'b1;
                    end else begin
                        d_rdata_d = mem_rdata;
                        d_dv_d    = 1'b1;
                    end
                    mem_rd_d = 1'b0;
                    state_d  = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        if (state_q == RD_I) i_err_d = 1'b1;
                        else                 d_err_d = 1'b1;
                        mem_rd_d = 1'b0;
                        state_d  = GAP;
                    end
                end
            end
            WR_D: begin
                mem_wr_d = 1'b0;
                d_dv_d   = 1'b1;
                state_d  = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_i_q    <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_len_q   <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            i_dv_q      <= 1'b0;
            d_dv_q      <= 1'b0;
            i_err_q     <= 1'b0;
            d_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_i_q    <= last_i_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_len_q   <= mem_len_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            i_dv_q      <= i_dv_d;
            d_dv_q      <= d_dv_d;
            i_err_q     <= i_err_d;
            d_err_q     <= d_err_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_len   = mem_len_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign i_dv      = i_dv_q;
    assign d_dv      = d_dv_q;
    assign i_err     = i_err_q;
    assign d_err     = d_err_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 512, meaning the memory read line width in bits (equal to CMEM_LINE).
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning the maximum cycles to wait for mem_dv on a read.
REQ-003 SHALL have port clk, input, width 1: the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-005 SHALL have port i_rd, input, width 1: instruction-side read request (level).
REQ-006 SHALL have port i_addr, input, width 64: instruction-side line address.
REQ-007 SHALL have port i_rdata, output, width LINE_W: instruction-side returned line.
REQ-008 SHALL have port i_dv, output, width 1: instruction-side completion pulse.
REQ-009 SHALL have ports d_rd and d_wr, inputs, width 1 each: data-side read and write requests (level).
REQ-010 SHALL have ports d_addr (input, 64), d_wdata (input, 64) and d_len (input, 2): data-side address, write data, and write size of 2**d_len bytes.
REQ-011 SHALL have ports d_rdata (output, LINE_W), d_dv (output, 1) and d_err (output, 1): data-side returned line, completion pulse, and timeout pulse.
REQ-012 SHALL have port i_err, output, width 1: instruction-side timeout pulse.
REQ-013 SHALL have ports mem_addr (output, 64), mem_wdata (output, 64), mem_len (output, 2), mem_rd (output, 1) and mem_wr (output, 1): the memory request port; memory acts on rising edges of mem_rd and mem_wr.
REQ-014 SHALL have ports mem_rdata (input, LINE_W) and mem_dv (input, 1): the memory read return; mem_dv is a 1-cycle pulse.

Function
REQ-015 SHALL implement an FSM with states IDLE, RD_I, RD_D, WR_D and GAP.
REQ-016 In IDLE, the arbiter SHALL pick a requester each cycle; the next state and all mem_* outputs SHALL be registered, so mem_rd or mem_wr rises the cycle after the grant decision.
REQ-017 When both sides request, the arbiter SHALL grant round-robin: the side not granted last wins; after reset, the data side wins first.
REQ-018 If d_wr and d_rd are both high, the data request SHALL be treated as a write.
REQ-019 On entering RD_I or RD_D, the arbiter SHALL latch the address into mem_addr and hold mem_rd high, with mem_addr stable, until mem_dv is sampled high or a timeout occurs.
REQ-020 On mem_dv in RD_x, the arbiter SHALL capture mem_rdata into the granted side's rdata register, pulse that side's dv for exactly 1 cycle on the next cycle, deassert mem_rd, and go to GAP.
REQ-021 On entering WR_D, the arbiter SHALL latch d_addr, d_wdata and d_len, and hold mem_wr high for exactly 1 cycle.
REQ-022 After that WR_D cycle, the arbiter SHALL pulse d_dv for 1 cycle and go to GAP; no write return is expected from memory.
REQ-023 GAP SHALL last exactly 1 cycle with mem_rd = mem_wr = 0, guaranteeing a fresh rising edge for the next request, then return to IDLE.
REQ-024 The minimum spacing between consecutive mem_rd or mem_wr rises SHALL therefore be 2 cycles after the previous completion.
REQ-025 mem_dv sampled in IDLE, GAP or WR_D SHALL be ignored, with no dv, rdata or error effect.
REQ-026 A wait counter SHALL count cycles in RD_x; if it reaches TIMEOUT without mem_dv, the arbiter SHALL pulse the granted side's err (no dv), drop mem_rd, and go to GAP.
REQ-027 The wait counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL clear on every entry to RD_x.
REQ-028 A requester dropping its request mid-transaction SHALL NOT abort it; the transaction completes and the dv pulse is still issued.
REQ-029 A requester SHALL hold its request until its dv or err pulse; a request still high in the cycle after dv is a new request.
REQ-030 i_rdata and d_rdata SHALL hold their last captured value until the next capture on that side.
REQ-031 At most one memory transaction SHALL be outstanding at any time.

Reset
REQ-032 While rst is high at a clock edge, the arbiter SHALL enter IDLE and drive mem_rd, mem_wr, i_dv, d_dv, i_err and d_err to 0.
REQ-033 Reset SHALL clear mem_addr, mem_wdata, mem_len, i_rdata, d_rdata and the wait counter to 0, and set round-robin priority to data-first.
REQ-034 Reset mid-transaction SHALL abandon it with no dv pulse; a late mem_dv after reset is ignored per REQ-025.

Verification
REQ-035 Single read: i_rd with i_addr = 0x8000_0040; memory returns mem_dv 8 cycles after the mem_rd rise -> mem_rd held 8 cycles, one i_dv pulse with i_rdata equal to the line, then 1 GAP cycle.
REQ-036 Contention: i_rd and d_rd rise in the same cycle after reset -> data served first, then instruction; the bench checks 2 distinct mem_rd rises separated by a low cycle.
REQ-037 Write: d_wr with d_addr = 0x8000_0100, d_wdata = 0xDEADBEEF, d_len = 2 -> mem_wr high exactly 1 cycle with matching mem_addr/mem_wdata/mem_len, then a d_dv pulse; read-back of that address returns 0xDEADBEEF in bytes 0-3.
REQ-038 Timeout: the bench never asserts mem_dv for an i_rd -> i_err pulses after 64 cycles, no i_dv, and the next request proceeds normally.
REQ-039 Reset mid-read: rst asserted 3 cycles into RD_D, then mem_dv arrives -> no d_dv, all outputs 0, state IDLE.
REQ-040 Back-to-back: d_rd held continuously for 3 reads -> 3 d_dv pulses, with each new mem_rd rise exactly 2 cycles after the previous mem_dv.
